// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-port integer register file for the RISC-V core. It has NWR write
//   ports and NRD read ports. A read can optionally be forwarded from a write
//   in the same cycle. Register x0 can be hardwired to zero. A per-register
//   busy scoreboard is set by decode (alloc) and cleared by writeback (write).
//
// Parameters
//   XLEN      data width of each register
//   NREGS     number of architectural registers (power of 2, >= 2)
//   NRD       number of read ports
//   NWR       number of write ports
//   BYPASS    1: a read of a register written this cycle returns the write data
//   ZERO_REG  1: register 0 reads as 0, and writes/allocs to it are ignored
//
// Ports
//   clk, resetn         rising-edge clock, asynchronous active-low reset
//   we/waddr/wdata      per-port write enable, address and data (port k at k*AW / k*XLEN)
//   raddr/rdata/rbusy   per-port read address, data and busy bit (combinational)
//   alloc_en/alloc_addr mark a destination register busy
//   flush               clear every busy bit; register contents are kept
//   busy_vec            full scoreboard state
//   wr_conflict         registered pulse: two or more ports wrote one register last cycle
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy_vec,
  output logic                 wr_conflict
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic             conflict_c;

  logic [AW-1:0]    wa [NWR];
  logic [XLEN-1:0]  wd [NWR];
  logic [NWR-1:0]   wv;
  logic [AW-1:0]    ra [NRD];

  // Unpack the flat port buses. A write is "effective" unless it targets the
  // hardwired-zero register, so x0 never stores data, never flags a
  // conflict and never touches the scoreboard.
  for (genvar k = 0; k < NWR; k++) begin : g_wunpack
    assign wa[k] = waddr[k*AW +: AW];
    assign wd[k] = wdata[k*XLEN +: XLEN];
    assign wv[k] = we[k] && !((ZERO_REG != 0) && (wa[k] == '0));
  end

  for (genvar j = 0; j < NRD; j++) begin : g_runpack
    assign ra[j] = raddr[j*AW +: AW];
  end

  // Storage. Ports are visited in ascending order, so the highest-index port
  // writing a given register provides the last assignment and wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wv[k]) begin
          regs[wa[k]] <= wd[k];
        end
      end
    end
  end

  // Same-register collision between any pair of effective write ports.
  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wv[i] && wv[j] && (wa[i] == wa[j])) begin
          conflict_c = 1'b1;
        end
      end
    end
  end

  // Scoreboard next state. The assignments are applied from lowest to
  // highest priority, so later ones override earlier ones: a retiring write
  // clears the bit, a new alloc wins over that clear, and flush wins over
  // everything (an alloc in a flush cycle is dropped).
  always_comb begin
    busy_nxt = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wv[k]) begin
        busy_nxt[wa[k]] = 1'b0;
      end
    end
    if (alloc_en) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    if (ZERO_REG != 0) begin
      busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy_q      <= busy_nxt;
      wr_conflict <= conflict_c;
    end
  end

  assign busy_vec = busy_q;

  // Read ports. The forward path scans write ports in ascending order, so the
  // highest-index hit wins. It uses the raw enable because x0 reads are forced
  // to zero afterwards anyway. rbusy shows registered state only; a write in
  // this cycle does not clear it early.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      logic [XLEN-1:0] rd;
      rd = regs[ra[j]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && (wa[k] == ra[j])) begin
            rd = wd[k];
          end
        end
      end
      if ((ZERO_REG != 0) && (ra[j] == '0)) begin
        rd = '0;
      end
      rdata[j*XLEN +: XLEN] = rd;
      rbusy[j]              = busy_q[ra[j]];
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_sb
//   Drives two register-file instances with identical inputs. One has
//   BYPASS=1 and the other BYPASS=0; both have 32x32, 2 read and 2 write
//   ports, and ZERO_REG=1.
//   The driver updates an array-based reference model. It then pushes the
//   expected outputs for the cycle into a queue. A monitor pops each entry on
//   the falling clock edge and compares it with both DUTs.
// ---------------------------------------------------------------------------
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [NWR-1:0] we = '0;
  logic [NWR*AW-1:0] waddr = '0;
  logic [NWR*XLEN-1:0] wdata = '0;
  logic [NRD*AW-1:0] raddr = '0;
  logic alloc_en = 1'b0;
  logic [AW-1:0] alloc_addr = '0;
  logic flush = 1'b0;

  logic [NRD*XLEN-1:0] rdata_b, rdata_n;
  logic [NRD-1:0] rbusy_b, rbusy_n;
  logic [NREGS-1:0] bv_b, bv_n;
  logic cf_b, cf_n;

  always #5 clk = ~clk;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) u_dut_byp (
    .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rbusy(rbusy_b), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush), .busy_vec(bv_b), .wr_conflict(cf_b));

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) u_dut_nob (
    .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_n), .rbusy(rbusy_n), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush), .busy_vec(bv_n), .wr_conflict(cf_n));

  // Reference model state
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy_m;
  logic conf_m;

  // Staged inputs for the next cycle (s_*) and inputs currently applied (a_*)
  logic s_we [NWR];
  logic [AW-1:0] s_wa [NWR];
  logic [XLEN-1:0] s_wd [NWR];
  logic [AW-1:0] s_ra [NRD];
  logic s_alloc, s_flush, s_rstn;
  logic [AW-1:0] s_aa;

  logic a_we [NWR];
  logic [AW-1:0] a_wa [NWR];
  logic [XLEN-1:0] a_wd [NWR];
  logic [AW-1:0] a_ra [NRD];
  logic a_alloc, a_flush, a_rstn;
  logic [AW-1:0] a_aa;

  typedef struct packed {
    logic [NRD*XLEN-1:0] rd_b;
    logic [NRD*XLEN-1:0] rd_n;
    logic [NRD-1:0] rb;
    logic [NREGS-1:0] bv;
    logic cf;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Expected read. x0 is always zero. With forwarding, the highest-numbered
  // enabled write port that targets the address supplies the data.
  // Otherwise the stored value is returned.
  function automatic logic [XLEN-1:0] read_exp(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp) begin
      for (int k = NWR - 1; k >= 0; k--) begin
        if (a_we[k] && a_wa[k] == a) return a_wd[k];
      end
    end
    return mem[a];
  endfunction

  function automatic int writers_of(input int a);
    int n = 0;
    for (int k = 0; k < NWR; k++) if (a_we[k] && a_wa[k] == AW'(a)) n++;
    return n;
  endfunction

  // Clock-edge update of the model from the inputs applied during the
  // cycle that is ending.
  task automatic commit();
    logic [XLEN-1:0] nmem [NREGS];
    logic [NREGS-1:0] nbusy;
    logic nconf;
    nconf = 1'b0;
    nbusy = busy_m;
    for (int a = 0; a < NREGS; a++) nmem[a] = mem[a];
    for (int a = 1; a < NREGS; a++) begin
      if (writers_of(a) >= 2) nconf = 1'b1;
      for (int k = NWR - 1; k >= 0; k--) begin
        if (a_we[k] && a_wa[k] == AW'(a)) begin
          nmem[a] = a_wd[k];
          break;
        end
      end
      if (a_flush) nbusy[a] = 1'b0;
      else if (a_alloc && a_aa == AW'(a)) nbusy[a] = 1'b1;
      else if (writers_of(a) > 0) nbusy[a] = 1'b0;
    end
    nbusy[0] = 1'b0;
    for (int a = 0; a < NREGS; a++) mem[a] = nmem[a];
    busy_m = nbusy;
    conf_m = nconf;
  endtask

  task automatic clear_model();
    for (int a = 0; a < NREGS; a++) mem[a] = '0;
    busy_m = '0;
    conf_m = 1'b0;
  endtask

  task automatic idle();
    for (int k = 0; k < NWR; k++) begin
      s_we[k] = 1'b0; s_wa[k] = '0; s_wd[k] = '0;
    end
    for (int j = 0; j < NRD; j++) s_ra[j] = '0;
    s_alloc = 1'b0; s_aa = '0; s_flush = 1'b0; s_rstn = 1'b1;
  endtask

  // One cycle: clock edge (model commit), then apply staged inputs just
  // after the edge and push the expected outputs for this cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (a_rstn) commit();
    #1;
    for (int k = 0; k < NWR; k++) begin
      a_we[k] = s_we[k]; a_wa[k] = s_wa[k]; a_wd[k] = s_wd[k];
      we[k] = s_we[k];
      waddr[k*AW +: AW] = s_wa[k];
      wdata[k*XLEN +: XLEN] = s_wd[k];
    end
    for (int j = 0; j < NRD; j++) begin
      a_ra[j] = s_ra[j];
      raddr[j*AW +: AW] = s_ra[j];
    end
    a_alloc = s_alloc; a_aa = s_aa; a_flush = s_flush; a_rstn = s_rstn;
    alloc_en = s_alloc; alloc_addr = s_aa; flush = s_flush; resetn = s_rstn;
    if (!a_rstn) clear_model();
    for (int j = 0; j < NRD; j++) begin
      e.rd_b[j*XLEN +: XLEN] = read_exp(a_ra[j], 1'b1);
      e.rd_n[j*XLEN +: XLEN] = read_exp(a_ra[j], 1'b0);
      e.rb[j] = busy_m[a_ra[j]];
    end
    e.bv = busy_m;
    e.cf = conf_m;
    exp_q.push_back(e);
  endtask

  // Monitor: compare both instances against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int j = 0; j < NRD; j++) begin
          chk($sformatf("rdata_byp[%0d]", j), 64'(rdata_b[j*XLEN +: XLEN]), 64'(e.rd_b[j*XLEN +: XLEN]));
          chk($sformatf("rdata_nob[%0d]", j), 64'(rdata_n[j*XLEN +: XLEN]), 64'(e.rd_n[j*XLEN +: XLEN]));
        end
        chk("rbusy_byp", 64'(rbusy_b), 64'(e.rb));
        chk("rbusy_nob", 64'(rbusy_n), 64'(e.rb));
        chk("busy_vec_byp", 64'(bv_b), 64'(e.bv));
        chk("busy_vec_nob", 64'(bv_n), 64'(e.bv));
        chk("wr_conflict_byp", 64'(cf_b), 64'(e.cf));
        chk("wr_conflict_nob", 64'(cf_n), 64'(e.cf));
      end
    end
  end

  initial begin
    idle();
    clear_model();
    for (int k = 0; k < NWR; k++) begin
      a_we[k] = 1'b0; a_wa[k] = '0; a_wd[k] = '0;
    end
    for (int j = 0; j < NRD; j++) a_ra[j] = '0;
    a_alloc = 1'b0; a_aa = '0; a_flush = 1'b0; a_rstn = 1'b0;

    // T1: write during reset is lost
    idle(); s_rstn = 1'b0; s_we[0] = 1'b1; s_wa[0] = 5'd5; s_wd[0] = 32'hDEAD_BEEF; s_ra[0] = 5'd5; tick();
    idle(); s_rstn = 1'b0; s_ra[0] = 5'd5; tick();
    idle(); s_ra[0] = 5'd5; s_ra[1] = 5'd3; tick();
    idle(); s_ra[0] = 5'd5; tick();

    // T2: write x3 and (ignored) x0
    idle(); s_we[0] = 1'b1; s_wa[0] = 5'd3; s_wd[0] = 32'h1234_5678;
    s_we[1] = 1'b1; s_wa[1] = 5'd0; s_wd[1] = 32'hFFFF_FFFF; tick();
    idle(); s_ra[0] = 5'd3; s_ra[1] = 5'd0; tick();

    // T3: same-cycle forward versus one-cycle latency
    idle(); s_we[0] = 1'b1; s_wa[0] = 5'd7; s_wd[0] = 32'hA5A5_A5A5; s_ra[0] = 5'd7; tick();
    idle(); s_ra[0] = 5'd7; tick();

    // T4: collision, highest port wins, one-cycle conflict pulse
    idle(); s_we[0] = 1'b1; s_wa[0] = 5'd9; s_wd[0] = 32'h1111;
    s_we[1] = 1'b1; s_wa[1] = 5'd9; s_wd[1] = 32'h2222; s_ra[0] = 5'd9; s_ra[1] = 5'd9; tick();
    idle(); s_ra[0] = 5'd9; tick();
    idle(); s_ra[0] = 5'd9; tick();

    // T5: scoreboard alloc/retire priority and x0
    idle(); s_alloc = 1'b1; s_aa = 5'd4; tick();
    idle(); s_ra[0] = 5'd4; tick();
    idle(); s_alloc = 1'b1; s_aa = 5'd4; s_we[0] = 1'b1; s_wa[0] = 5'd4; s_wd[0] = 32'h44; s_ra[0] = 5'd4; tick();
    idle(); s_ra[0] = 5'd4; tick();
    idle(); s_we[0] = 1'b1; s_wa[0] = 5'd4; s_wd[0] = 32'h45; s_ra[0] = 5'd4; tick();
    idle(); s_ra[0] = 5'd4; tick();
    idle(); s_alloc = 1'b1; s_aa = 5'd0; tick();
    idle(); tick();

    // T6: flush drops a same-cycle alloc, then asynchronous reset mid-operation
    for (int r = 1; r <= 3; r++) begin
      idle(); s_alloc = 1'b1; s_aa = AW'(r); tick();
    end
    idle(); s_ra[0] = 5'd2; s_flush = 1'b1; s_alloc = 1'b1; s_aa = 5'd5; tick();
    idle(); s_ra[0] = 5'd5; tick();
    idle(); s_alloc = 1'b1; s_aa = 5'd6; s_we[1] = 1'b1; s_wa[1] = 5'd8; s_wd[1] = 32'h8888; tick();
    idle(); s_ra[0] = 5'd8; s_ra[1] = 5'd6; tick();
    idle(); s_rstn = 1'b0; s_ra[0] = 5'd8; s_ra[1] = 5'd6; tick();
    idle(); s_ra[0] = 5'd8; s_ra[1] = 5'd6; tick();

    // Randomized traffic; addresses are mostly 0..7 so collisions, forwards and x0 are frequent
    for (int n = 0; n < 3000; n++) begin
      idle();
      for (int k = 0; k < NWR; k++) begin
        s_we[k] = ($urandom_range(0, 99) < 50);
        s_wa[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
        s_wd[k] = $urandom;
      end
      for (int j = 0; j < NRD; j++) begin
        s_ra[j] = ($urandom_range(0, 2) == 0) ? s_wa[$urandom_range(0, NWR - 1)] : AW'($urandom_range(0, 7));
      end
      s_alloc = ($urandom_range(0, 99) < 40);
      s_aa = AW'($urandom_range(0, 7));
      s_flush = ($urandom_range(0, 99) < 3);
      s_rstn = ($urandom_range(0, 199) != 0);
      tick();
    end

    idle(); tick();
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
